// File: rtl/pmbist_march_engine_pkg.sv
// Shared definitions for the PMBIST march engine: instruction layout, field
// extraction helpers and FSM state encoding.
package pmbist_march_engine_pkg;

  localparam int unsigned SCAN_WIDTH = 21;

  // Instruction word: {W, DATA[7:0], POL[3:0], OP[3:0], NO[1:0], ADMD, UPDWN}
  localparam int unsigned IrUpdwn   = 0;
  localparam int unsigned IrAdmd    = 1;
  localparam int unsigned IrNoLsb   = 2;
  localparam int unsigned IrOpLsb   = 4;
  localparam int unsigned IrPolLsb  = 8;
  localparam int unsigned IrDataLsb = 12;
  localparam int unsigned IrDataW   = 8;
  localparam int unsigned IrW       = 20;

  typedef logic [SCAN_WIDTH-1:0] ir_t;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain,
    StDone
  } state_e;

  function automatic logic ir_updwn(ir_t ir);
    return ir[IrUpdwn];
  endfunction

  function automatic logic ir_admd(ir_t ir);
    return ir[IrAdmd];
  endfunction

  function automatic logic [1:0] ir_no(ir_t ir);
    return ir[IrNoLsb +: 2];
  endfunction

  function automatic logic [3:0] ir_op(ir_t ir);
    return ir[IrOpLsb +: 4];
  endfunction

  function automatic logic [3:0] ir_pol(ir_t ir);
    return ir[IrPolLsb +: 4];
  endfunction

  function automatic logic [IrDataW-1:0] ir_data(ir_t ir);
    return ir[IrDataLsb +: IrDataW];
  endfunction

  function automatic logic ir_w(ir_t ir);
    return ir[IrW];
  endfunction

endpackage

// File: rtl/pmbist_addr_gen.sv
// Address sweep counter: loads the start address, steps up or down, and flags
// the final address of the sweep (always address 0 in single-address mode).
module pmbist_addr_gen #(
  parameter int unsigned ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  step,
  input  logic                  updwn,
  input  logic                  single,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  last
);

  logic [ADDR_WIDTH-1:0] addr_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q <= '0;
    end else if (load) begin
      addr_q <= (updwn && !single) ? '1 : '0;
    end else if (step) begin
      addr_q <= updwn ? addr_q - ADDR_WIDTH'(1) : addr_q + ADDR_WIDTH'(1);
    end
  end

  assign addr = addr_q;
  assign last = single || (updwn ? (addr_q == '0) : (addr_q == '1));

endmodule

// File: rtl/pmbist_march_engine.sv
// March-element engine: sequences up to four read/write ops per address over a
// sweep, generates per-op data and checks reads through a one-stage compare.
module pmbist_march_engine
  import pmbist_march_engine_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [SCAN_WIDTH-1:0] scan,
  input  logic                  ts,
  output logic                  busy,
  output logic                  done,
  output logic                  passfail,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [1:0]            fail_op,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  state_e                state_q, state_d;
  ir_t                   instr_q;
  logic [1:0]            op_q;
  logic                  passfail_q;
  logic [ADDR_WIDTH-1:0] fail_addr_q;
  logic [1:0]            fail_op_q;
  logic                  cmp_valid_q;
  logic [DATA_WIDTH-1:0] cmp_exp_q;
  logic [ADDR_WIDTH-1:0] cmp_addr_q;
  logic [1:0]            cmp_op_q;

  logic                  accept, run, op_last, step, last, op_we, op_pol;
  logic                  gen_updwn, gen_single;
  logic [3:0]            op_bits, pol_bits;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] bg, pat, data;
  logic [IrDataW-1:0]    ir_bg;

  assign accept   = (state_q == StIdle) && ts;
  assign run      = (state_q == StRun);
  assign op_bits  = ir_op(instr_q);
  assign pol_bits = ir_pol(instr_q);
  assign op_we    = op_bits[op_q];
  assign op_pol   = pol_bits[op_q];
  assign op_last  = (op_q == ir_no(instr_q));
  assign step     = run && op_last && !last;

  // The instruction is not latched yet on the accepting edge, so decode scan directly.
  assign gen_updwn  = accept ? ir_updwn(scan) : ir_updwn(instr_q);
  assign gen_single = accept ? ir_admd(scan)  : ir_admd(instr_q);

  pmbist_addr_gen #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_addr_gen (
    .clk   (clk),
    .rst   (rst),
    .load  (accept),
    .step  (step),
    .updwn (gen_updwn),
    .single(gen_single),
    .addr  (addr),
    .last  (last)
  );

  assign ir_bg = ir_data(instr_q);

  if (DATA_WIDTH > IrDataW) begin : g_bg_ext
    assign bg = {{(DATA_WIDTH - IrDataW){1'b0}}, ir_bg};
  end else if (DATA_WIDTH == IrDataW) begin : g_bg_eq
    assign bg = ir_bg;
  end else begin : g_bg_trunc
    assign bg = ir_bg[DATA_WIDTH-1:0];
  end

  assign pat  = bg ^ {DATA_WIDTH{ir_w(instr_q) & addr[0]}};
  assign data = pat ^ {DATA_WIDTH{op_pol}};

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (ts) state_d = StRun;
      StRun:   if (op_last && last) state_d = StDrain;
      StDrain: state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      instr_q <= '0;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        instr_q <= scan;
        op_q    <= '0;
      end else if (run) begin
        op_q <= op_last ? 2'd0 : op_q + 2'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cmp_valid_q <= 1'b0;
      cmp_exp_q   <= '0;
      cmp_addr_q  <= '0;
      cmp_op_q    <= '0;
    end else begin
      cmp_valid_q <= run && !op_we;
      cmp_exp_q   <= data;
      cmp_addr_q  <= addr;
      cmp_op_q    <= op_q;
    end
  end

  // No read is ever pending in IDLE, so clear-on-accept never races a compare.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      passfail_q  <= 1'b0;
      fail_addr_q <= '0;
      fail_op_q   <= '0;
    end else if (accept) begin
      passfail_q  <= 1'b0;
      fail_addr_q <= '0;
      fail_op_q   <= '0;
    end else if (cmp_valid_q && (mem_rdata != cmp_exp_q)) begin
      passfail_q <= 1'b1;
      if (!passfail_q) begin
        fail_addr_q <= cmp_addr_q;
        fail_op_q   <= cmp_op_q;
      end
    end
  end

  assign busy      = run || (state_q == StDrain);
  assign done      = (state_q == StDone);
  assign passfail  = passfail_q;
  assign fail_addr = fail_addr_q;
  assign fail_op   = fail_op_q;
  assign mem_en    = run;
  assign mem_we    = run && op_we;
  assign mem_addr  = run ? addr : '0;
  assign mem_wdata = (run && op_we) ? data : '0;

endmodule

// File: tb/tb_pmbist_march_engine.sv
// Scoreboard bench for pmbist_march_engine: expected accesses and results are
// queued by the stimulus and checked by a negedge monitor against a memory model.
module tb_pmbist_march_engine;

  localparam int unsigned AW = 4;
  localparam int unsigned DW = 8;

  typedef struct {
    int           cyc;
    logic         we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } acc_t;

  typedef struct {
    int           cyc;
    logic         pf;
    logic [AW-1:0] fa;
    logic [1:0]   fo;
  } res_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [20:0]   scan = '0;
  logic          ts = 1'b0;
  logic          busy, done, passfail, mem_en, mem_we;
  logic [AW-1:0] fail_addr, mem_addr;
  logic [1:0]    fail_op;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;

  logic [DW-1:0] mem    [16];
  logic [DW-1:0] stuck0 [16];

  acc_t exp_acc[$];
  res_t exp_res[$];
  time  t0 = 0;
  int   checks = 0;
  int   errors = 0;

  pmbist_march_engine #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .scan     (scan),
    .ts       (ts),
    .busy     (busy),
    .done     (done),
    .passfail (passfail),
    .fail_addr(fail_addr),
    .fail_op  (fail_op),
    .mem_en   (mem_en),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Synchronous memory with per-address stuck-at-0 bit masks.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata & ~stuck0[mem_addr];
      else        mem_rdata     <= mem[mem_addr] & ~stuck0[mem_addr];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    int   cyc;
    acc_t a;
    res_t r;
    if (rst) begin
      cyc = int'(($time - t0 + 5) / 10);
      if (mem_en) begin
        if (exp_acc.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_access: got addr %0h we %0b, expected none", mem_addr, mem_we);
        end else begin
          a = exp_acc.pop_front();
          chk("acc_cycle", cyc, a.cyc);
          chk("acc_we", 32'(mem_we), 32'(a.we));
          chk("acc_addr", 32'(mem_addr), 32'(a.addr));
          if (a.we) chk("acc_wdata", 32'(mem_wdata), 32'(a.data));
        end
      end
      if (done) begin
        if (exp_res.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done=1, expected none");
        end else begin
          r = exp_res.pop_front();
          chk("done_cycle", cyc, r.cyc);
          chk("passfail", 32'(passfail), 32'(r.pf));
          chk("fail_addr", 32'(fail_addr), 32'(r.fa));
          chk("fail_op", 32'(fail_op), 32'(r.fo));
        end
      end
    end
  end

  function automatic logic [20:0] mk_ir(logic updwn, logic admd, logic [1:0] no, logic [3:0] op,
                                        logic [3:0] pol, logic [7:0] data, logic w);
    return {w, data, pol, op, no, admd, updwn};
  endfunction

  task automatic push_acc(int cyc, logic we, logic [AW-1:0] addr, logic [DW-1:0] data);
    acc_t a;
    a.cyc = cyc; a.we = we; a.addr = addr; a.data = data;
    exp_acc.push_back(a);
  endtask

  task automatic push_res(int cyc, logic pf, logic [AW-1:0] fa, logic [1:0] fo);
    res_t r;
    r.cyc = cyc; r.pf = pf; r.fa = fa; r.fo = fo;
    exp_res.push_back(r);
  endtask

  // Expected access stream of a sweep; returns the op count.
  task automatic push_sweep(input logic updwn, input logic admd, input logic [1:0] no,
                            input logic [3:0] op, input logic [3:0] pol, input logic [7:0] data,
                            input logic w, output int n);
    int            n_addr;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    n = 0;
    n_addr = admd ? 1 : 16;
    for (int ai = 0; ai < n_addr; ai++) begin
      a = admd ? 4'd0 : (updwn ? 4'(15 - ai) : 4'(ai));
      for (int k = 0; k <= int'(no); k++) begin
        d = data ^ ((w && a[0]) ? 8'hFF : 8'h00);
        d = d ^ (pol[k] ? 8'hFF : 8'h00);
        n++;
        push_acc(n, op[k], a, d);
      end
    end
  endtask

  task automatic start(input logic [20:0] ir);
    @(posedge clk);
    #1 scan = ir;
    ts = 1'b1;
    @(posedge clk);
    t0 = $time;
    #1 ts = 1'b0;
  endtask

  task automatic finish_run(input int n, input string name);
    repeat (n + 3) @(posedge clk);
    #1;
    chk({name, "_acc_left"}, exp_acc.size(), 0);
    chk({name, "_res_left"}, exp_res.size(), 0);
    chk({name, "_busy_after"}, 32'(busy), 0);
    exp_acc.delete();
    exp_res.delete();
  endtask

  initial begin
    int n;
    for (int i = 0; i < 16; i++) begin
      mem[i] = '0;
      stuck0[i] = '0;
    end

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_passfail", 32'(passfail), 0);
    chk("rst_mem_en", 32'(mem_en), 0);
    chk("rst_mem_we", 32'(mem_we), 0);
    chk("rst_mem_addr", 32'(mem_addr), 0);
    chk("rst_mem_wdata", 32'(mem_wdata), 0);
    chk("rst_fail_addr", 32'(fail_addr), 0);
    chk("rst_fail_op", 32'(fail_op), 0);
    rst = 1'b1;

    // Single address: W FA, R FA, W 05, R 05 at addr 0; done in cycle 6.
    push_acc(1, 1'b1, 4'd0, 8'hFA);
    push_acc(2, 1'b0, 4'd0, 8'hFA);
    push_acc(3, 1'b1, 4'd0, 8'h05);
    push_acc(4, 1'b0, 4'd0, 8'h05);
    push_res(6, 1'b0, 4'd0, 2'd0);
    start(mk_ir(1'b0, 1'b1, 2'd3, 4'b0101, 4'b1100, 8'hFA, 1'b0));
    finish_run(4, "single");

    // Full ascending sweep, 32 ops, done in cycle 34.
    push_sweep(1'b0, 1'b0, 2'd1, 4'b0001, 4'b0000, 8'h55, 1'b0, n);
    chk("asc_op_count", n, 32);
    push_res(34, 1'b0, 4'd0, 2'd0);
    start(mk_ir(1'b0, 1'b0, 2'd1, 4'b0001, 4'b0000, 8'h55, 1'b0));
    finish_run(32, "asc");

    // Descending checkerboard: first access W AA @15, then 55 at addr 14.
    push_sweep(1'b1, 1'b0, 2'd1, 4'b0001, 4'b0000, 8'h55, 1'b1, n);
    chk("desc_first_data", 32'(exp_acc[0].data), 32'h0AA);
    chk("desc_first_addr", 32'(exp_acc[0].addr), 15);
    push_res(34, 1'b0, 4'd0, 2'd0);
    start(mk_ir(1'b1, 1'b0, 2'd1, 4'b0001, 4'b0000, 8'h55, 1'b1));
    finish_run(32, "desc");

    // Stuck-at-0 bit 0 at addr 7 and addr 9: first failure stays at 7, op 1.
    stuck0[7] = 8'h01;
    stuck0[9] = 8'h01;
    push_sweep(1'b0, 1'b0, 2'd1, 4'b0001, 4'b0000, 8'h01, 1'b0, n);
    push_res(34, 1'b1, 4'd7, 2'd1);
    start(mk_ir(1'b0, 1'b0, 2'd1, 4'b0001, 4'b0000, 8'h01, 1'b0));
    finish_run(32, "fault");
    stuck0[7] = 8'h00;
    stuck0[9] = 8'h00;

    // ts in cycle 5 and in the DONE cycle are both ignored.
    push_sweep(1'b0, 1'b0, 2'd1, 4'b0001, 4'b0000, 8'h55, 1'b0, n);
    push_res(34, 1'b0, 4'd0, 2'd0);
    start(mk_ir(1'b0, 1'b0, 2'd1, 4'b0001, 4'b0000, 8'h55, 1'b0));
    repeat (4) @(posedge clk);
    #1 scan = mk_ir(1'b1, 1'b1, 2'd3, 4'b1111, 4'b1111, 8'hC3, 1'b1);
    ts = 1'b1;
    @(posedge clk);
    #1 ts = 1'b0;
    repeat (28) @(posedge clk);
    #1 ts = 1'b1;
    @(posedge clk);
    #1 ts = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("restart_acc_left", exp_acc.size(), 0);
    chk("restart_res_left", exp_res.size(), 0);
    chk("restart_busy_after", 32'(busy), 0);
    exp_acc.delete();
    exp_res.delete();

    // Reset asserted in cycle 10: outputs drop at once, no done pulse.
    push_sweep(1'b0, 1'b0, 2'd1, 4'b0001, 4'b0000, 8'h55, 1'b0, n);
    start(mk_ir(1'b0, 1'b0, 2'd1, 4'b0001, 4'b0000, 8'h55, 1'b0));
    repeat (9) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_mem_en", 32'(mem_en), 0);
    chk("midrst_mem_addr", 32'(mem_addr), 0);
    chk("midrst_mem_we", 32'(mem_we), 0);
    exp_acc.delete();
    exp_res.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    chk("midrst_idle_busy", 32'(busy), 0);

    // Normal run after reset.
    push_acc(1, 1'b1, 4'd0, 8'hFA);
    push_acc(2, 1'b0, 4'd0, 8'hFA);
    push_acc(3, 1'b1, 4'd0, 8'h05);
    push_acc(4, 1'b0, 4'd0, 8'h05);
    push_res(6, 1'b0, 4'd0, 2'd0);
    start(mk_ir(1'b0, 1'b1, 2'd3, 4'b0101, 4'b1100, 8'hFA, 1'b0));
    finish_run(4, "after_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pmbist_march_engine.md
# pmbist_march_engine

March-element execution engine for the programmable memory BIST. Consumes the instruction word delivered on the scan bus when the test-start strobe pulses, sweeps the memory address space up or down, and issues up to four read/write operations per address with per-operation data polarity. It compares read data against the expected pattern and drives the sticky `passfail` result plus first-failure diagnostics. It sits between the scan/instruction input and the memory under test inside `memory_ip_block`.

## Interface
- `ADDR_WIDTH`, 4: memory address bits; sweep covers 2^ADDR_WIDTH words.
- `DATA_WIDTH`, 8: memory word width; the instruction DATA field is zero-extended or truncated to this width.

- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `scan` input `SCAN_WIDTH`: instruction word; sampled only on an accepted `ts`.
- `ts` input 1: test start; accepted only when idle.
- `busy` output 1: engine running.
- `done` output 1: single-cycle completion pulse.
- `passfail` output 1: sticky result; 1 = fail, 0 = pass.
- `fail_addr` output ADDR_WIDTH: address of the first mismatch.
- `fail_op` output 2: operation index of the first mismatch.
- `mem_en` output 1: memory access strobe.
- `mem_we` output 1: 1 = write, 0 = read; valid while `mem_en` is high.
- `mem_addr` output ADDR_WIDTH: access address.
- `mem_wdata` output DATA_WIDTH: write data.
- `mem_rdata` input DATA_WIDTH: read data; valid the cycle after a read issue (synchronous memory).

## Operation
- **Instruction fields**, decoded from the `defines.v` macros:
  - UPDWN: 0 = ascending, 1 = descending.
  - ADMD: 1 = single address 0 only, 0 = full sweep.
  - NO: operations per address minus 1.
  - OPk: 1 = write, 0 = read.
  - POLk: 1 = invert data.
  - DATA: background pattern.
  - W: 1 = checkerboard.
- **Pattern** for address a: P = DATA ^ {DATA_WIDTH{W & a[0]}}. Operation k uses D = P ^ {DATA_WIDTH{POLk}}. Writes drive D; reads expect D.
- **Accepting `ts`:** when `ts` is high in IDLE, the engine latches `scan`, clears `passfail`/`fail_addr`/`fail_op`, and sets the start address (0, or 2^ADDR_WIDTH-1 if descending and ADMD=0).
- **FSM:**
  - IDLE → RUN on `ts`.
  - RUN issues one operation per cycle: op index 0..NO, then advance the address.
  - RUN → DRAIN after the final operation at the last address. The sweep ends at the last address; there is no wrap-around.
  - DRAIN compares the last pending read, then goes to DONE.
  - DONE pulses `done`, then returns to IDLE.
- **Compare pipeline:** a one-stage register holds {valid read, expected data, addr, op}. A mismatch sets `passfail`. `fail_addr`/`fail_op` capture only on the first mismatch.
- `ts` while busy is ignored; the latched instruction is unaffected.
- Op count N = (NO+1) × (ADMD ? 1 : 2^ADDR_WIDTH).

## Timing
- **Cycle numbering:** cycle 0 is the edge where `ts` is sampled.
  - Operations are issued in cycles 1..N.
  - DRAIN is cycle N+1.
  - `done` is high in cycle N+2, with `passfail` already final.
- `busy` is high in cycles 1..N+1.
- A read issued in cycle t is compared at the end of cycle t+1; `passfail` is visible from cycle t+2.
- **Reset values:** `busy`, `done`, `passfail`, `mem_en`, `mem_we` = 0; `mem_addr`, `mem_wdata`, `fail_addr`, `fail_op` = 0; FSM in IDLE.
- **Reset mid-run:** all outputs drop to reset values immediately (asynchronously); no `done` pulse.
- `ts` coincident with the DONE cycle is ignored. A new test may start from the cycle after `done`.
- `mem_en` is low in every cycle outside RUN.

## Structure
- Additions to the shared package `defines.v`:
  - `SCAN_WIDTH`.
  - Field extraction macros for the `IR_*` fields (bit positions/widths of UPDWN, OPk, POLk, NO, DATA, W, ADMD).
  - FSM state encodings.
- Sub-module `pmbist_addr_gen`:
  - Ports: load, step, up/down, single-address mode.
  - Outputs: addr, last.
  - Instantiated once.
- Op sequencing, pattern generation and the compare pipeline live in this module.

## Test plan
- **Single-address test:** ADMD=1, NO=3, OP=W,R,W,R, POL=0,0,1,1, DATA=FA, fault-free memory.
  - Accesses: write FA, read FA, write 05, read 05, all at addr 0.
  - `done` in cycle 6, `passfail`=0.
- **Full ascending sweep:** ADMD=0, UPDWN=0, NO=1, OP=W,R, DATA=55, W=0.
  - Addresses 0..15, 32 operations.
  - `done` in cycle 34, `passfail`=0.
- **Descending checkerboard:** UPDWN=1, W=1, DATA=55, OP0=W.
  - First access is a write of AA at addr 15; addr 14 gets 55.
  - `passfail`=0.
- **Fault injection:** bit 0 of addr 7 stuck-at-0; sweep with W then R of DATA=01.
  - `passfail`=1 at `done`; `fail_addr`=7, `fail_op`=1.
  - A second stuck bit at addr 9 does not change `fail_addr`.
- **Restart and reset:**
  - `ts` pulsed in cycle 5 of a run → ignored; op count unchanged.
  - `rst` low in cycle 10 → `busy`/`mem_en` drop at once, no `done`.
  - A new `ts` after reset runs normally.
